// File: rtl/spi_fbw_slave_if.sv
// Bundles the SPI pins and the frame-buffer write/commit port of spi_fbw_slave.
interface spi_fbw_slave_if #(
  parameter int N_ROWS = 64,
  parameter int N_COLS = 64
);
  localparam int LOG_N_ROWS = $clog2(N_ROWS);
  localparam int LOG_N_COLS = $clog2(N_COLS);

  logic                  spi_sck;
  logic                  spi_cs_n;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic [LOG_N_ROWS-1:0] fbw_row_addr;
  logic [LOG_N_COLS-1:0] fbw_col_addr;
  logic [7:0]            fbw_data;
  logic                  fbw_wren;
  logic                  fbw_row_store;
  logic                  fbw_row_swap;
  logic                  fbw_row_rdy;
  logic                  frame_swap;
  logic                  frame_rdy;

  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, fbw_row_rdy, frame_rdy,
    output spi_miso, fbw_row_addr, fbw_col_addr, fbw_data, fbw_wren,
           fbw_row_store, fbw_row_swap, frame_swap
  );

  modport master (
    output spi_sck, spi_cs_n, spi_mosi, fbw_row_rdy, frame_rdy,
    input  spi_miso, fbw_row_addr, fbw_col_addr, fbw_data, fbw_wren,
           fbw_row_store, fbw_row_swap, frame_swap
  );
endinterface

// File: rtl/spi_fbw_slave.sv
// SPI mode-0 slave that receives one row of 8-bit pixels at a time, writes them
// into a frame buffer, and commits rows or whole frames through handshakes.
// A status byte is returned on MISO at the start of every transaction.
module spi_fbw_slave #(
  parameter int N_ROWS = 64,
  parameter int N_COLS = 64
) (
  input logic           clk,
  input logic           rst_n,
  spi_fbw_slave_if.slave bus
);
  localparam int BITDEPTH   = 8;
  localparam int LOG_N_ROWS = $clog2(N_ROWS);
  localparam int LOG_N_COLS = $clog2(N_COLS);
  localparam logic [LOG_N_COLS-1:0] LAST_COL = LOG_N_COLS'(N_COLS - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, PIXEL, STORE, SWAP, DISCARD} state_t;

  state_t                state_q, state_d;
  logic [1:0]            sckSync_q, csSync_q, mosiSync_q;
  logic                  sckPrev_q, csPrev_q;
  logic [2:0]            bitCnt_q, bitCnt_d;
  logic [6:0]            rxShift_q, rxShift_d;
  logic [7:0]            txShift_q, txShift_d;
  logic                  miso_q, miso_d;
  logic [LOG_N_ROWS-1:0] rowAddr_q, rowAddr_d;
  logic [LOG_N_COLS-1:0] colCnt_q, colCnt_d;
  logic [LOG_N_COLS-1:0] colAddr_q, colAddr_d;
  logic [BITDEPTH-1:0]   data_q, data_d;
  logic                  wren_q, wren_d;
  logic                  rowStore_q, rowStore_d;
  logic                  frameSwap_q, frameSwap_d;
  logic                  overrun_q, overrun_d;

  logic                  csHigh, csFall, csRise, sckRise, sckFall, mosiBit;
  logic                  byteDone, busy;
  logic [BITDEPTH-1:0]   rxByte;
  logic [7:0]            status;

  assign csHigh   = csSync_q[1];
  assign csFall   = csPrev_q & ~csSync_q[1];
  assign csRise   = ~csPrev_q & csSync_q[1];
  assign sckRise  = sckSync_q[1] & ~sckPrev_q;
  assign sckFall  = ~sckSync_q[1] & sckPrev_q;
  assign mosiBit  = mosiSync_q[1];
  assign rxByte   = {rxShift_q, mosiBit};
  assign byteDone = sckRise & ~csHigh & (bitCnt_q == 3'd7);
  assign busy     = (state_q == STORE) || (state_q == SWAP);
  assign status   = {busy, overrun_q, 4'b0000, bus.frame_rdy, bus.fbw_row_rdy};

  // Two-flop synchronizers for the SPI pins plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sckSync_q  <= 2'b00;
      csSync_q   <= 2'b11;
      mosiSync_q <= 2'b00;
      sckPrev_q  <= 1'b0;
      csPrev_q   <= 1'b1;
    end else begin
      sckSync_q  <= {sckSync_q[0], bus.spi_sck};
      csSync_q   <= {csSync_q[0], bus.spi_cs_n};
      mosiSync_q <= {mosiSync_q[0], bus.spi_mosi};
      sckPrev_q  <= sckSync_q[1];
      csPrev_q   <= csSync_q[1];
    end
  end

  // Receive and transmit shifters; the status snapshot is taken at cs fall.
  always_comb begin
    bitCnt_d  = bitCnt_q;
    rxShift_d = rxShift_q;
    txShift_d = txShift_q;
    miso_d    = miso_q;
    if (csHigh || csFall) begin
      bitCnt_d  = 3'd0;
      rxShift_d = 7'd0;
    end else if (sckRise) begin
      bitCnt_d  = bitCnt_q + 3'd1;
      rxShift_d = rxByte[6:0];
    end
    if (csHigh) begin
      txShift_d = 8'd0;
      miso_d    = 1'b0;
    end else if (csFall) begin
      miso_d    = status[7];
      txShift_d = {status[6:0], 1'b0};
    end else if (sckFall) begin
      miso_d    = txShift_q[7];
      txShift_d = {txShift_q[6:0], 1'b0};
    end
  end

  // Protocol sequencing: command, row address, pixels, then row or frame commit.
  always_comb begin
    state_d     = state_q;
    rowAddr_d   = rowAddr_q;
    colCnt_d    = colCnt_q;
    colAddr_d   = colAddr_q;
    data_d      = data_q;
    wren_d      = 1'b0;
    rowStore_d  = 1'b0;
    frameSwap_d = 1'b0;
    overrun_d   = overrun_q;
    if (csFall) overrun_d = 1'b0;
    case (state_q)
      IDLE: if (csFall) state_d = CMD;
      CMD: begin
        if (csRise) state_d = IDLE;
        else if (byteDone) begin
          if (rxByte == 8'h80)      state_d = ADDR;
          else if (rxByte == 8'h81) state_d = SWAP;
          else                      state_d = DISCARD;
        end
      end
      ADDR: begin
        if (csRise) state_d = IDLE;
        else if (byteDone) begin
          rowAddr_d = rxByte[LOG_N_ROWS-1:0];
          colCnt_d  = '0;
          state_d   = PIXEL;
        end
      end
      PIXEL: begin
        if (csRise) state_d = IDLE;
        else if (byteDone) begin
          wren_d    = 1'b1;
          data_d    = rxByte;
          colAddr_d = colCnt_q;
          colCnt_d  = colCnt_q + LOG_N_COLS'(1);
          if (colCnt_q == LAST_COL) state_d = STORE;
        end
      end
      STORE: begin
        if (csFall) overrun_d = 1'b1;
        if (bus.fbw_row_rdy) begin
          rowStore_d = 1'b1;
          state_d    = IDLE;
        end
      end
      SWAP: begin
        if (csFall) overrun_d = 1'b1;
        if (bus.frame_rdy) begin
          frameSwap_d = 1'b1;
          state_d     = IDLE;
        end
      end
      DISCARD: if (csRise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bitCnt_q    <= 3'd0;
      rxShift_q   <= 7'd0;
      txShift_q   <= 8'd0;
      miso_q      <= 1'b0;
      rowAddr_q   <= '0;
      colCnt_q    <= '0;
      colAddr_q   <= '0;
      data_q      <= '0;
      wren_q      <= 1'b0;
      rowStore_q  <= 1'b0;
      frameSwap_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      rxShift_q   <= rxShift_d;
      txShift_q   <= txShift_d;
      miso_q      <= miso_d;
      rowAddr_q   <= rowAddr_d;
      colCnt_q    <= colCnt_d;
      colAddr_q   <= colAddr_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
      rowStore_q  <= rowStore_d;
      frameSwap_q <= frameSwap_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.spi_miso      = miso_q;
  assign bus.fbw_row_addr  = rowAddr_q;
  assign bus.fbw_col_addr  = colAddr_q;
  assign bus.fbw_data      = data_q;
  assign bus.fbw_wren      = wren_q;
  assign bus.fbw_row_store = rowStore_q;
  assign bus.fbw_row_swap  = rowStore_q;
  assign bus.frame_swap    = frameSwap_q;
endmodule

// File: doc/spi_fbw_slave.md
SPI_FBW_SLAVE -- requirements
Module: spi_fbw_slave

Interface
REQ-001 Parameter N_ROWS, default 64, total panel rows (all banks); row address width LOG_N_ROWS = clog2(N_ROWS).
REQ-002 Parameter N_COLS, default 64, pixels per row; column address width LOG_N_COLS = clog2(N_COLS).
REQ-003 Parameter BITDEPTH, fixed at 8, pixel width; one SPI byte carries one pixel.
REQ-004 clk  input  1  system clock; one clock domain; all logic is clocked on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous and active-low.
REQ-006 spi_sck / spi_cs_n / spi_mosi  input  1 each  SPI mode 0 from the host; asynchronous to clk; f_sck <= f_clk/4.
REQ-007 spi_miso  output  1  status data to the host.
REQ-008 fbw_row_addr  output  LOG_N_ROWS  target row.
REQ-009 fbw_col_addr  output  LOG_N_COLS; fbw_data  output  8; fbw_wren  output  1  pixel write port.
REQ-010 fbw_row_store  output  1; fbw_row_swap  output  1; fbw_row_rdy  input  1  row-commit handshake.
REQ-011 frame_swap  output  1; frame_rdy  input  1  frame-commit handshake.

Function
REQ-012 spi_sck, spi_cs_n and spi_mosi each pass through a 2-flop synchronizer; sck rise/fall and cs fall/rise are detected on the synchronized signals.
REQ-013 mosi is sampled MSB first on detected sck rise; a byte completes on the 8th rise after cs fall or after the previous byte.
REQ-014 FSM states: IDLE, CMD, ADDR, PIXEL, STORE, SWAP, DISCARD.
REQ-015 Detected cs fall: FSM in IDLE -> CMD; FSM in STORE or SWAP -> stays, sets sticky overrun, and the transaction is ignored until cs rise.
REQ-016 Byte 0 (command) in CMD: 0x80 -> ADDR; 0x81 -> SWAP; any other value -> DISCARD.
REQ-017 Byte 1 in ADDR: fbw_row_addr <= byte[LOG_N_ROWS-1:0]; column counter <= 0; -> PIXEL.
REQ-018 In PIXEL, each completed byte produces exactly one fbw_wren cycle, on the cycle after completion, with fbw_data = byte and fbw_col_addr = counter; the counter then increments.
REQ-019 When the byte with counter = N_COLS-1 is written: -> STORE; bytes beyond N_COLS are ignored, with no wrap.
REQ-020 STORE waits for fbw_row_rdy=1; in that cycle fbw_row_store=1 and fbw_row_swap=1 for exactly one cycle; then -> IDLE.
REQ-021 SWAP waits for frame_rdy=1; in that cycle frame_swap=1 for exactly one cycle; then -> IDLE.
REQ-022 cs rise in CMD, ADDR, PIXEL or DISCARD: -> IDLE; the partial byte is dropped and there is no store; pixels already written stay in the buffer.
REQ-023 cs rise in STORE or SWAP does not abort the pending commit.
REQ-024 Status byte = {busy, overrun, 4'b0, frame_rdy, fbw_row_rdy}; busy=1 in STORE or SWAP.
REQ-025 At every detected cs fall, the status is snapshotted into the MISO shift register; overrun clears in the same cycle unless it is being set by that cs fall.
REQ-026 spi_miso presents the snapshot MSB as soon as it is loaded, shifts to the next bit on each detected sck fall, outputs 0 after 8 bits, and outputs 0 whenever cs is high (no tri-state).
REQ-027 fbw_wren, fbw_row_store, fbw_row_swap and frame_swap are never asserted outside the conditions above; all outputs are registered.

Reset
REQ-028 While rst_n=0: FSM=IDLE; synchronizers = idle levels (sck 0, cs 1, mosi 0); all strobes 0; fbw_row_addr, fbw_col_addr, fbw_data = 0; spi_miso = 0; overrun = 0; shift registers = 0.
REQ-029 rst_n assertion mid-transaction aborts it immediately; after release, the block waits for a fresh cs fall.

Verification
REQ-030 cs fall, bytes 0x80, 0x05, then 64 bytes 0x00..0x3F, fbw_row_rdy=1 -> 64 fbw_wren pulses with col k / data k, row_addr=5, then one-cycle row_store+row_swap.
REQ-031 Same transaction with fbw_row_rdy=0 for 20 cycles after the last byte -> store strobe appears exactly in the first cycle rdy=1; second cs fall during the wait sets overrun and writes nothing.
REQ-032 Byte 0x81 with frame_rdy=0, then 1 -> single frame_swap in the first frame_rdy=1 cycle.
REQ-033 Row write with cs raised after 10 pixels plus 3 bits -> 10 wren pulses, no store, FSM IDLE.
REQ-034 Status read after the overrun of REQ-031 with frame_rdy=1, row_rdy=1 -> MISO byte 0x43; next read -> 0x03.
REQ-035 rst_n low for 1 cycle mid-PIXEL -> all outputs at reset values; next 0x80 transaction completes normally.
